seq_div_restoring: RTL

- Multi-cycle unsigned restoring divider; the inverse operation of the team's combinational array multiplier.
- Computes quotient and remainder one bit per clock using a start/done handshake.
- Sits beside the multiplier in the arithmetic library.
- Bench checks it against the multiplier identity: quotient*divisor + remainder == dividend.

---
 rtl/seq_div_restoring.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seq_div_restoring.sv
// seq_div_restoring
//   Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   Companion to the combinational array multiplier in the arithmetic library.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, accepted on a rising edge while ready is high
//   dividend     unsigned numerator, captured with start
//   divisor      unsigned denominator, captured with start
//   ready        high in IDLE and DONE; start is only accepted then
//   busy         high while iterating
//   done         one-cycle pulse when quotient/remainder/div_by_zero update
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   div_by_zero  registered flag for the last completed operation

module seq_div_restoring #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  // The partial remainder is always restored to a value below the divisor,
  // so its extra top bit is only needed transiently after the shift.
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   shifted;
  logic             trial_ok;
  logic [WIDTH-1:0] part_next;
  logic [WIDTH-1:0] shreg_next;
  logic             accept;
  logic             last_iter;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and one restoring step
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    shifted    = {part, shreg[WIDTH-1]};
    // When the subtraction succeeds the true difference is below the
    // divisor, so modular WIDTH-bit subtraction yields it exactly.
    trial_ok   = (shifted >= {1'b0, dvs});
    part_next  = trial_ok ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
    shreg_next = {shreg[WIDTH-2:0], trial_ok};
    last_iter  = (count == CW'(1));

    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (divisor == '0) ? DONE : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      part        <= '0;
      shreg       <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        part  <= '0;
        shreg <= dividend;
        dvs   <= divisor;
        count <= CW'(WIDTH);
        // Divide by zero completes immediately with an all-ones quotient.
        if (divisor == '0) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
        end
      end else if (state == RUN) begin
        part  <= part_next;
        shreg <= shreg_next;
        count <= count - CW'(1);
        if (last_iter) begin
          quotient    <= shreg_next;
          remainder   <= part_next;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
        end
      end
    end
  end

  assign busy  = (state == RUN);
  assign ready = !busy;

endmodule
